// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of one main-memory port.
// Latency: grant one edge after the request, completion on the first edge with MEM_BUSYWAIT low, one DONE cycle.
// Backpressure: requesters stall on X_BUSYWAIT; memory stalls the served transfer by holding MEM_BUSYWAIT high.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  I_READ,
   input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
   output logic [DATA_WIDTH-1:0] I_READDATA,
   output logic                  I_BUSYWAIT,
   input  logic                  D_READ,
   input  logic                  D_WRITE,
   input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
   input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
   output logic [DATA_WIDTH-1:0] D_READDATA,
   output logic                  D_BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
   output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
   input  logic [DATA_WIDTH-1:0] MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   state_t                  state_q;
   state_t                  state_d;
   logic                    last_q;      // port served by the most recent completed transfer
   logic                    grant_i;
   logic                    grant_d;
   logic                    xfer_done;
   logic                    i_req;
   logic                    d_req;
   logic                    in_done;

   // Latched transfer registers; the memory side only ever sees these.
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    mem_read_q;
   logic                    mem_write_q;
   logic [DATA_WIDTH-1:0]   i_rdata_q;
   logic [DATA_WIDTH-1:0]   d_rdata_q;

   assign i_req = I_READ;
   assign d_req = D_READ | D_WRITE;

   // Next-state and grant decision; on a tie the port that was not served last wins.
   always_comb begin
      state_d   = state_q;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      xfer_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req && d_req) begin
               if (last_q == PORT_I) begin
                  grant_d = 1'b1;
               end else begin
                  grant_i = 1'b1;
               end
            end else if (i_req) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i) begin
               state_d = SERVE_I;
            end else if (grant_d) begin
               state_d = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (!MEM_BUSYWAIT) begin
               xfer_done = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            // Turnaround cycle: strobes are low and no grant is made here.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Remember the served port at completion; reset value makes the first tie go to D.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         last_q <= PORT_I;
      end else if (xfer_done) begin
         last_q <= (state_q == SERVE_D) ? PORT_D : PORT_I;
      end
   end

   // Capture address, data and operation at grant; drop the strobe at completion.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (grant_d) begin
         addr_q      <= D_ADDRESS;
         wdata_q     <= D_WRITEDATA;
         // A simultaneous read and write request is issued as a write.
         mem_write_q <= D_WRITE;
         mem_read_q  <= D_READ & ~D_WRITE;
      end else if (grant_i) begin
         addr_q      <= I_ADDRESS;
         wdata_q     <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b1;
      end else if (xfer_done) begin
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end
   end

   // Read data is captured even if the requester has already dropped its request.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (xfer_done && mem_read_q) begin
         if (state_q == SERVE_I) begin
            i_rdata_q <= MEM_READDATA;
         end else begin
            d_rdata_q <= MEM_READDATA;
         end
      end
   end

   // While reset is held the DONE release is suppressed so BUSYWAIT just follows the request.
   assign in_done    = (state_q == DONE) && !RESET;
   assign I_BUSYWAIT = i_req && !(in_done && (last_q == PORT_I));
   assign D_BUSYWAIT = d_req && !(in_done && (last_q == PORT_D));

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = addr_q;
   assign MEM_WRITEDATA = wdata_q;
   assign I_READDATA    = i_rdata_q;
   assign D_READDATA    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scoreboard of expected memory transfers plus a behavioural memory model.
// Latency: checks the one-edge grant, busywait-stretched transfers and the DONE turnaround cycle.
// Backpressure: memory stalls are programmable per scenario; requesters hold until BUSYWAIT drops.
module tb_mem_arbiter;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        I_READ = 1'b0;
   logic [31:0] I_ADDRESS = '0;
   logic [31:0] I_READDATA;
   logic        I_BUSYWAIT;
   logic        D_READ = 1'b0;
   logic        D_WRITE = 1'b0;
   logic [31:0] D_ADDRESS = '0;
   logic [31:0] D_WRITEDATA = '0;
   logic [31:0] D_READDATA;
   logic        D_BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [31:0] MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA = '0;
   logic        MEM_BUSYWAIT = 1'b1;

   xfer_t       sb[$];
   logic [31:0] mem [logic [31:0]];
   int          wait_cycles = 0;
   int          wait_cnt = 0;
   bit          gap_chk = 1'b0;
   int          checks = 0;
   int          failures = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory model: stalls for wait_cycles, then completes and checks against the scoreboard.
   always begin : mem_model
      xfer_t exp;
      @(negedge CLK);
      #1;
      if (gap_chk) begin
         gap_chk = 1'b0;
         checks++;
         if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin
            failures++;
            $display("FAIL turnaround: rd=%b wr=%b, required both 0 after completion", MEM_READ, MEM_WRITE);
         end
      end
      if ((MEM_READ === 1'b1 || MEM_WRITE === 1'b1) && RESET === 1'b0) begin
         if (wait_cnt < wait_cycles) begin
            MEM_BUSYWAIT = 1'b1;
            wait_cnt++;
         end else begin
            MEM_BUSYWAIT = 1'b0;
            wait_cnt = 0;
            MEM_READDATA = mem_rd(MEM_ADDRESS);
            gap_chk = 1'b1;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: rd=%b wr=%b addr=%h, required no transfer", MEM_READ, MEM_WRITE, MEM_ADDRESS);
            end else begin
               exp = sb.pop_front();
               if (MEM_WRITE !== exp.wr || MEM_READ !== ~exp.wr || MEM_ADDRESS !== exp.addr ||
                   (exp.wr && MEM_WRITEDATA !== exp.data)) begin
                  failures++;
                  $display("FAIL sb_xfer: rd=%b wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, exp.wr, exp.addr, exp.data);
               end
            end
            if (MEM_WRITE === 1'b1) mem[MEM_ADDRESS] = MEM_WRITEDATA;
         end
      end else begin
         MEM_BUSYWAIT = 1'b1;
         wait_cnt = 0;
      end
   end

   task automatic test_reset;
      @(negedge CLK);
      RESET = 1'b1; I_READ = 1'b1; D_WRITE = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (I_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_i_busy: got %b, required 1", I_BUSYWAIT); end
      checks++; if (D_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_d_busy: got %b, required 1", D_BUSYWAIT); end
      checks++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin failures++; $display("FAIL rst_strobes: rd=%b wr=%b, required 0 0", MEM_READ, MEM_WRITE); end
      checks++; if (MEM_ADDRESS !== 32'h0 || MEM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL rst_mem_bus: addr=%h wdata=%h, required 0 0", MEM_ADDRESS, MEM_WRITEDATA); end
      checks++; if (I_READDATA !== 32'h0 || D_READDATA !== 32'h0) begin failures++; $display("FAIL rst_rdata: i=%h d=%h, required 0 0", I_READDATA, D_READDATA); end
      I_READ = 1'b0; D_WRITE = 1'b0;
      @(negedge CLK);
      checks++; if (I_BUSYWAIT !== 1'b0 || D_BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_busy_idle: i=%b d=%b, required 0 0", I_BUSYWAIT, D_BUSYWAIT); end
      RESET = 1'b0;
   endtask

   task automatic test_min_latency;
      mem[32'h4] = 32'h0020_8333;
      wait_cycles = 0;
      @(negedge CLK);
      sb.push_back('{wr: 1'b0, addr: 32'h4, data: 32'h0});
      I_READ = 1'b1; I_ADDRESS = 32'h4;
      @(negedge CLK);
      checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 32'h4) begin failures++; $display("FAIL lat_cycle1: rd=%b addr=%h, required 1 00000004", MEM_READ, MEM_ADDRESS); end
      checks++; if (I_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL lat_busy1: got %b, required 1", I_BUSYWAIT); end
      @(negedge CLK);
      checks++; if (I_BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL lat_cycle2: busy=%b rd=%b, required 0 0", I_BUSYWAIT, MEM_READ); end
      checks++; if (I_READDATA !== 32'h0020_8333) begin failures++; $display("FAIL lat_rdata: got %h, required 00208333", I_READDATA); end
      I_READ = 1'b0; I_ADDRESS = 32'hFFFF_FFF0;
      @(negedge CLK);
      checks++; if (I_READDATA !== 32'h0020_8333) begin failures++; $display("FAIL lat_hold: got %h, required 00208333", I_READDATA); end
   endtask

   task automatic test_write_wait;
      int wr_cyc, low_cyc, rd_seen, bad_val;
      wr_cyc = 0; low_cyc = 0; rd_seen = 0; bad_val = 0;
      wait_cycles = 3;
      @(negedge CLK);
      sb.push_back('{wr: 1'b1, addr: 32'h100, data: 32'hDEAD_BEEF});
      D_WRITE = 1'b1; D_ADDRESS = 32'h100; D_WRITEDATA = 32'hDEAD_BEEF;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (MEM_WRITE === 1'b1) begin
            wr_cyc++;
            if (MEM_ADDRESS !== 32'h100 || MEM_WRITEDATA !== 32'hDEAD_BEEF) bad_val++;
         end
         if (MEM_READ !== 1'b0) rd_seen++;
         if (D_WRITE && D_BUSYWAIT === 1'b0) begin
            low_cyc++;
            D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
         end else if (c == 1) begin
            // Requester changes after the grant must not reach memory.
            D_ADDRESS = 32'h7FC; D_WRITEDATA = 32'h0;
         end
      end
      D_WRITE = 1'b0;
      checks++; if (wr_cyc != 4) begin failures++; $display("FAIL wr_strobe_len: got %0d cycles, required 4", wr_cyc); end
      checks++; if (bad_val != 0) begin failures++; $display("FAIL wr_latched: got %0d bad cycles, required 0", bad_val); end
      checks++; if (rd_seen != 0) begin failures++; $display("FAIL wr_no_read: got %0d read cycles, required 0", rd_seen); end
      checks++; if (low_cyc != 1) begin failures++; $display("FAIL wr_busy_pulse: got %0d, required 1", low_cyc); end
      checks++; if (I_READDATA !== 32'h0020_8333 || D_READDATA !== 32'h0) begin failures++; $display("FAIL wr_rdata_hold: i=%h d=%h, required 00208333 0", I_READDATA, D_READDATA); end
   endtask

   task automatic test_tie_after_reset;
      int i_low, d_low, i_at, d_at;
      i_low = 0; d_low = 0; i_at = -1; d_at = -1;
      wait_cycles = 0;
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      sb.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h0});
      sb.push_back('{wr: 1'b0, addr: 32'h20, data: 32'h0});
      D_READ = 1'b1; D_ADDRESS = 32'h40;
      I_READ = 1'b1; I_ADDRESS = 32'h20;
      for (int c = 0; c < 20 && (I_READ || D_READ); c++) begin
         @(negedge CLK);
         if (D_READ && D_BUSYWAIT === 1'b0) begin
            d_low++; d_at = c;
            checks++; if (D_READDATA !== mem_rd(32'h40)) begin failures++; $display("FAIL tie_d_rdata: got %h, required %h", D_READDATA, mem_rd(32'h40)); end
            D_READ = 1'b0;
         end
         if (I_READ && I_BUSYWAIT === 1'b0) begin
            i_low++; i_at = c;
            checks++; if (I_READDATA !== mem_rd(32'h20)) begin failures++; $display("FAIL tie_i_rdata: got %h, required %h", I_READDATA, mem_rd(32'h20)); end
            I_READ = 1'b0;
         end
      end
      I_READ = 1'b0; D_READ = 1'b0;
      checks++; if (d_low != 1 || i_low != 1) begin failures++; $display("FAIL tie_pulses: d=%0d i=%0d, required 1 1", d_low, i_low); end
      checks++; if (!(d_at >= 0 && d_at < i_at)) begin failures++; $display("FAIL tie_order: d_at=%0d i_at=%0d, required D before I", d_at, i_at); end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL tie_sb_left: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_round_robin;
      int ik, dk;
      ik = 0; dk = 0;
      wait_cycles = 1;
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{wr: 1'b1, addr: 32'h300 + 4 * k, data: 32'h1111_1111 * (k + 1)});
         sb.push_back('{wr: 1'b0, addr: 32'h400 + 4 * k, data: 32'h0});
      end
      @(negedge CLK);
      // Both D strobes high: the transfer must go out as a write.
      D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 32'h300; D_WRITEDATA = 32'h1111_1111;
      I_READ = 1'b1; I_ADDRESS = 32'h400;
      for (int c = 0; c < 80 && (ik < 3 || dk < 3); c++) begin
         @(negedge CLK);
         if (D_WRITE && D_BUSYWAIT === 1'b0) begin
            dk++;
            if (dk < 3) begin
               D_ADDRESS = 32'h300 + 4 * dk; D_WRITEDATA = 32'h1111_1111 * (dk + 1);
            end else begin
               D_READ = 1'b0; D_WRITE = 1'b0;
            end
         end
         if (I_READ && I_BUSYWAIT === 1'b0) begin
            checks++; if (I_READDATA !== mem_rd(I_ADDRESS)) begin failures++; $display("FAIL rr_i_rdata: got %h, required %h", I_READDATA, mem_rd(I_ADDRESS)); end
            ik++;
            if (ik < 3) I_ADDRESS = 32'h400 + 4 * ik;
            else I_READ = 1'b0;
         end
      end
      I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
      checks++; if (ik != 3 || dk != 3) begin failures++; $display("FAIL rr_counts: i=%0d d=%0d, required 3 3", ik, dk); end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL rr_sb_left: got %0d pending, required 0", sb.size()); end
   endtask

   task automatic test_reset_mid;
      int dlow;
      bit got;
      dlow = 0; got = 1'b0;
      wait_cycles = 100;
      @(negedge CLK);
      D_WRITE = 1'b1; D_ADDRESS = 32'h500; D_WRITEDATA = 32'h1234_5678;
      @(negedge CLK);
      checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDRESS !== 32'h500) begin failures++; $display("FAIL rm_serve: wr=%b addr=%h, required 1 00000500", MEM_WRITE, MEM_ADDRESS); end
      RESET = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         if (D_BUSYWAIT !== 1'b1) dlow++;
         if (c == 0) begin
            checks++; if (MEM_WRITE !== 1'b0 || MEM_READ !== 1'b0) begin failures++; $display("FAIL rm_strobes: rd=%b wr=%b, required 0 0", MEM_READ, MEM_WRITE); end
            checks++; if (MEM_ADDRESS !== 32'h0 || MEM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL rm_bus: addr=%h wdata=%h, required 0 0", MEM_ADDRESS, MEM_WRITEDATA); end
            checks++; if (I_READDATA !== 32'h0 || D_READDATA !== 32'h0) begin failures++; $display("FAIL rm_rdata: i=%h d=%h, required 0 0", I_READDATA, D_READDATA); end
         end
      end
      checks++; if (dlow != 0) begin failures++; $display("FAIL rm_no_pulse: got %0d low cycles, required 0", dlow); end
      D_WRITE = 1'b0; RESET = 1'b0; wait_cycles = 0;
      @(negedge CLK);
      sb.push_back('{wr: 1'b0, addr: 32'h100, data: 32'h0});
      D_READ = 1'b1; D_ADDRESS = 32'h100;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge CLK);
         if (D_BUSYWAIT === 1'b0) begin
            got = 1'b1;
            checks++; if (D_READDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rm_fresh_rdata: got %h, required deadbeef", D_READDATA); end
            D_READ = 1'b0;
         end
      end
      D_READ = 1'b0;
      checks++; if (!got) begin failures++; $display("FAIL rm_fresh_timeout: got no completion, required one"); end
   endtask

   task automatic test_drop_mid;
      bit seen, got;
      seen = 1'b0; got = 1'b0;
      wait_cycles = 2;
      @(negedge CLK);
      sb.push_back('{wr: 1'b0, addr: 32'h104, data: 32'h0});
      D_READ = 1'b1; D_ADDRESS = 32'h104;
      @(negedge CLK);
      checks++; if (MEM_READ !== 1'b1) begin failures++; $display("FAIL dm_serve: rd=%b, required 1", MEM_READ); end
      D_READ = 1'b0; D_ADDRESS = 32'h999;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge CLK);
         if (MEM_READ === 1'b0) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL dm_timeout: strobe never dropped, required completion"); end
      checks++; if (D_READDATA !== mem_rd(32'h104)) begin failures++; $display("FAIL dm_rdata: got %h, required %h", D_READDATA, mem_rd(32'h104)); end
      // New request raised in the DONE cycle must wait for IDLE.
      sb.push_back('{wr: 1'b0, addr: 32'h8, data: 32'h0});
      I_READ = 1'b1; I_ADDRESS = 32'h8;
      @(negedge CLK);
      checks++; if (MEM_READ !== 1'b0 || I_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL dm_idle: rd=%b busy=%b, required 0 1", MEM_READ, I_BUSYWAIT); end
      @(negedge CLK);
      checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 32'h8) begin failures++; $display("FAIL dm_regrant: rd=%b addr=%h, required 1 00000008", MEM_READ, MEM_ADDRESS); end
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge CLK);
         if (I_BUSYWAIT === 1'b0) begin
            got = 1'b1;
            checks++; if (I_READDATA !== mem_rd(32'h8)) begin failures++; $display("FAIL dm_i_rdata: got %h, required %h", I_READDATA, mem_rd(32'h8)); end
            I_READ = 1'b0;
         end
      end
      I_READ = 1'b0;
      checks++; if (!got || sb.size() != 0) begin failures++; $display("FAIL dm_finish: done=%b pending=%0d, required 1 0", got, sb.size()); end
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_write_wait();
      test_tie_after_reset();
      test_round_robin();
      test_reset_mid();
      test_drop_mid();
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
